wb_trace_emitter: RTL and testbench

WB_TRACE_EMITTER -- requirements
Module: wb_trace_emitter

---
 rtl/wb_trace_emitter_pkg.sv | 26 ++
 rtl/wb_trace_emitter_fifo.sv | 85 ++++++++
 rtl/wb_trace_emitter.sv | 109 ++++++++++
 tb/tb_wb_trace_emitter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_emitter_pkg.sv
// Shared field widths and trace-entry layouts for the write-back trace emitter.
// The timestamped layout is used when TRACE_TIMESTAMP_EN is defined.
package wb_trace_emitter_pkg;

    localparam int REG_W   = 5;
    localparam int DATA_W  = 32;
    localparam int CYCLE_W = 16;

    typedef struct packed {
        logic [REG_W-1:0]   regNum;
        logic [DATA_W-1:0]  value;
        logic [CYCLE_W-1:0] cycle;
    } traceEntry_t;

    typedef struct packed {
        logic [REG_W-1:0]  regNum;
        logic [DATA_W-1:0] value;
    } traceEntryNoTs_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occState_t;

endpackage

// File: rtl/wb_trace_emitter_fifo.sv
// trace_fifo: circular entry store with modulo-DEPTH pointers and an occupancy
// counter; empty/full are decoded from occupancy alone.
module trace_fifo
    import wb_trace_emitter_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = REG_W + DATA_W
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wrData,
    output logic [WIDTH-1:0]         rdData,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_V = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wrPtr_r;
    logic [PTR_W-1:0] rdPtr_r;
    logic [PTR_W:0]   count_r;
    occState_t        occState_s;
    logic             pushEff_s;
    logic             popEff_s;

    // Occupancy state decode.
    always_comb begin
        occState_s = OCC_PARTIAL;
        if (count_r == {(PTR_W + 1){1'b0}}) begin
            occState_s = OCC_EMPTY;
        end else if (count_r == DEPTH_V) begin
            occState_s = OCC_FULL;
        end else begin
            occState_s = OCC_PARTIAL;
        end
    end

    assign full      = (occState_s == OCC_FULL);
    assign empty     = (occState_s == OCC_EMPTY);
    // A pop frees the slot the push lands in, so a full FIFO still accepts it.
    assign pushEff_s = push & (~full | pop);
    assign popEff_s  = pop & ~empty;
    assign rdData    = mem_r[rdPtr_r];
    assign occupancy = count_r;

    // Entry storage; cleared on reset so the head fields read zero.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (pushEff_s) begin
            mem_r[wrPtr_r] <= wrData;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wrPtr_r <= {PTR_W{1'b0}};
            rdPtr_r <= {PTR_W{1'b0}};
            count_r <= {(PTR_W + 1){1'b0}};
        end else begin
            if (pushEff_s) begin
                wrPtr_r <= wrPtr_r + PTR_ONE;
            end
            if (popEff_s) begin
                rdPtr_r <= rdPtr_r + PTR_ONE;
            end
            case ({pushEff_s, popEff_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/wb_trace_emitter.sv
// Captures WB-stage register writes into a trace FIFO with drop accounting.
// Define TRACE_TIMESTAMP_EN to add the 16-bit cycle counter and per-entry timestamp.
module wb_trace_emitter
    import wb_trace_emitter_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   traceEn,
    input  logic                   wbRegWrite,
    input  logic [REG_W-1:0]       wbRegDst,
    input  logic [DATA_W-1:0]      wbData,
    output logic                   traceValid,
    input  logic                   traceReady,
    output logic [REG_W-1:0]       traceReg,
    output logic [DATA_W-1:0]      traceValue,
    output logic [CYCLE_W-1:0]     traceCycle,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [DROP_W-1:0]      dropCount,
    input  logic                   clearDrop,
    output logic                   overflow
);

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = $bits(traceEntry_t);
    traceEntry_t        wrEntry_s;
    traceEntry_t        headEntry_s;
    logic [CYCLE_W-1:0] cycle_r;
`else
    localparam int ENTRY_W = $bits(traceEntryNoTs_t);
    traceEntryNoTs_t    wrEntry_s;
    traceEntryNoTs_t    headEntry_s;
`endif

    logic               event_s;
    logic               pop_s;
    logic               drop_s;
    logic               full_s;
    logic               empty_s;
    logic [ENTRY_W-1:0] rdData_s;
    logic [DROP_W-1:0]  dropCount_r;
    logic               overflow_r;

    assign event_s    = traceEn & wbRegWrite & (wbRegDst != {REG_W{1'b0}});
    assign pop_s      = traceValid & traceReady;
    assign drop_s     = event_s & full_s & ~pop_s;
    assign traceValid = ~empty_s;

`ifdef TRACE_TIMESTAMP_EN
    // Free-running timestamp, wraps at 16 bits.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cycle_r <= {CYCLE_W{1'b0}};
        end else begin
            cycle_r <= cycle_r + 16'd1;
        end
    end

    assign wrEntry_s  = {wbRegDst, wbData, cycle_r};
    assign traceCycle = headEntry_s.cycle;
`else
    assign wrEntry_s  = {wbRegDst, wbData};
    assign traceCycle = {CYCLE_W{1'b0}};
`endif

    assign headEntry_s = rdData_s;
    assign traceReg    = headEntry_s.regNum;
    assign traceValue  = headEntry_s.value;

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .resetN    (resetN),
        .push      (event_s),
        .pop       (pop_s),
        .wrData    (wrEntry_s),
        .rdData    (rdData_s),
        .occupancy (occupancy),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Saturating drop counter and sticky overflow; clear wins over a same-cycle drop.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dropCount_r <= {DROP_W{1'b0}};
            overflow_r  <= 1'b0;
        end else if (clearDrop) begin
            dropCount_r <= {DROP_W{1'b0}};
            overflow_r  <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (dropCount_r != DROP_MAX) begin
                dropCount_r <= dropCount_r + DROP_ONE;
            end
        end
    end

    assign dropCount = dropCount_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_wb_trace_emitter.sv
// Directed self-checking bench for wb_trace_emitter (DEPTH=8, DROP_W=8).
// Timestamp expectations collapse to 0 when TRACE_TIMESTAMP_EN is undefined.
module tb_wb_trace_emitter;

    localparam int DEPTH  = 8;
    localparam int DROP_W = 8;
`ifdef TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetN;
    logic        traceEn;
    logic        wbRegWrite;
    logic [4:0]  wbRegDst;
    logic [31:0] wbData;
    logic        traceValid;
    logic        traceReady;
    logic [4:0]  traceReg;
    logic [31:0] traceValue;
    logic [15:0] traceCycle;
    logic [3:0]  occupancy;
    logic [7:0]  dropCount;
    logic        clearDrop;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] cyc = 16'd0;
    logic [15:0] lastCap = 16'd0;
    logic [15:0] capCyc [10];
    logic [15:0] capNew;

    wb_trace_emitter #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .traceEn    (traceEn),
        .wbRegWrite (wbRegWrite),
        .wbRegDst   (wbRegDst),
        .wbData     (wbData),
        .traceValid (traceValid),
        .traceReady (traceReady),
        .traceReg   (traceReg),
        .traceValue (traceValue),
        .traceCycle (traceCycle),
        .occupancy  (occupancy),
        .dropCount  (dropCount),
        .clearDrop  (clearDrop),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expCyc(input logic [15:0] c);
        return TS_EN ? {16'd0, c} : 32'd0;
    endfunction

    // One clock: remember the timestamp the edge would capture, then sample 1 time unit after it.
    task automatic step();
        lastCap = cyc;
        @(posedge clk);
        if (resetN) cyc = cyc + 16'd1;
        #1;
    endtask

    initial begin
        resetN = 1'b0; traceEn = 1'b0; wbRegWrite = 1'b0; wbRegDst = 5'd0;
        wbData = 32'd0; traceReady = 1'b0; clearDrop = 1'b0;
        step(); step();
        check("rst_valid", 32'(traceValid), 32'd0);
        check("rst_reg",   32'(traceReg),   32'd0);
        check("rst_value", traceValue,      32'd0);
        check("rst_cycle", 32'(traceCycle), 32'd0);
        check("rst_occ",   32'(occupancy),  32'd0);
        check("rst_drop",  32'(dropCount),  32'd0);
        check("rst_ovf",   32'(overflow),   32'd0);

        // Single event captured at cycle 3, popped on the following edge.
        resetN = 1'b1; cyc = 16'd0;
        step(); step(); step();
        traceEn = 1'b1; wbRegWrite = 1'b1; wbRegDst = 5'd5; wbData = 32'h0000002A; traceReady = 1'b1;
        step();
        wbRegWrite = 1'b0;
        check("one_valid", 32'(traceValid), 32'd1);
        check("one_reg",   32'(traceReg),   32'd5);
        check("one_value", traceValue,      32'h2A);
        check("one_cycle", 32'(traceCycle), expCyc(16'd3));
        check("one_occ",   32'(occupancy),  32'd1);
        step();
        check("one_popped_valid", 32'(traceValid), 32'd0);
        check("one_popped_occ",   32'(occupancy),  32'd0);

        // Writes to $0 are never events.
        wbRegWrite = 1'b1; wbRegDst = 5'd0;
        for (int i = 0; i < 10; i++) begin
            wbData = 32'(i);
            step();
            check("r0_occ",   32'(occupancy),  32'd0);
            check("r0_valid", 32'(traceValid), 32'd0);
        end
        wbRegWrite = 1'b0;

        // Ten events into an 8-deep FIFO with no consumer: two drops.
        traceReady = 1'b0; wbRegWrite = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wbRegDst = 5'(i + 1);
            wbData = 32'h100 + 32'(i);
            step();
            capCyc[i] = lastCap;
        end
        wbRegWrite = 1'b0;
        step();
        check("full_occ",   32'(occupancy),  32'd8);
        check("full_drop",  32'(dropCount),  32'd2);
        check("full_ovf",   32'(overflow),   32'd1);
        check("full_reg",   32'(traceReg),   32'd1);
        check("full_value", traceValue,      32'h100);
        check("full_cycle", 32'(traceCycle), expCyc(capCyc[0]));
        step();
        check("hold_reg",   32'(traceReg),   32'd1);
        check("hold_value", traceValue,      32'h100);

        // Push and pop together while full: accepted, no drop.
        traceReady = 1'b1; wbRegWrite = 1'b1; wbRegDst = 5'd11; wbData = 32'h200;
        step();
        capNew = lastCap;
        wbRegWrite = 1'b0;
        check("pp_occ",  32'(occupancy), 32'd8);
        check("pp_drop", 32'(dropCount), 32'd2);

        // Drain: events 2..8 then the entry pushed while full.
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", 32'(traceValid), 32'd1);
            check("drain_reg",   32'(traceReg),   (i < 7) ? 32'(i + 2) : 32'd11);
            check("drain_value", traceValue,      (i < 7) ? 32'h100 + 32'(i + 1) : 32'h200);
            check("drain_cycle", 32'(traceCycle), expCyc((i < 7) ? capCyc[i + 1] : capNew));
            step();
        end
        check("drained_valid", 32'(traceValid), 32'd0);
        check("drained_occ",   32'(occupancy),  32'd0);

        // Refill, then clearDrop against a same-cycle drop.
        traceReady = 1'b0; wbRegWrite = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wbRegDst = 5'(i + 20);
            wbData = 32'(i);
            step();
        end
        clearDrop = 1'b1;
        step();
        clearDrop = 1'b0;
        check("clr_pri_drop", 32'(dropCount), 32'd0);
        check("clr_pri_ovf",  32'(overflow),  32'd0);
        check("clr_pri_occ",  32'(occupancy), 32'd8);
        step();
        check("drop1_cnt", 32'(dropCount), 32'd1);
        check("drop1_ovf", 32'(overflow),  32'd1);
        repeat (300) step();
        check("sat_drop", 32'(dropCount), 32'd255);
        check("sat_ovf",  32'(overflow),  32'd1);
        check("sat_occ",  32'(occupancy), 32'd8);
        wbRegWrite = 1'b0; clearDrop = 1'b1;
        step();
        clearDrop = 1'b0;
        check("clr_drop", 32'(dropCount), 32'd0);
        check("clr_ovf",  32'(overflow),  32'd0);

        // Drain four with capture disabled.
        traceEn = 1'b0; traceReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("off_drain_reg", 32'(traceReg), 32'(i + 20));
            step();
        end
        traceReady = 1'b0;
        check("four_occ", 32'(occupancy), 32'd4);
        check("four_reg", 32'(traceReg),  32'd24);

        // Mid-stream reset clears the queue immediately.
        #2;
        resetN = 1'b0;
        cyc = 16'd0;
        #1;
        check("arst_valid", 32'(traceValid), 32'd0);
        check("arst_occ",   32'(occupancy),  32'd0);
        check("arst_reg",   32'(traceReg),   32'd0);
        step();
        resetN = 1'b1; traceEn = 1'b1; wbRegWrite = 1'b1; wbRegDst = 5'd7; wbData = 32'h0000DEAD;
        step();
        wbRegWrite = 1'b0;
        check("post_valid", 32'(traceValid), 32'd1);
        check("post_occ",   32'(occupancy),  32'd1);
        check("post_reg",   32'(traceReg),   32'd7);
        check("post_value", traceValue,      32'hDEAD);
        check("post_cycle", 32'(traceCycle), expCyc(16'd0));
        traceReady = 1'b1;
        step();
        check("post_pop_valid", 32'(traceValid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
